sc_noise_frame_ctrl: RTL and testbench
======================================

// Module: sc_noise_frame_ctrl
// PURPOSE
//  Sequences one stochastic-computing frame through the M x N parallel 3x3 median noise filter.
//  - Loads and steps the shared LFSR that feeds the pixel SNGs.
//  - Enables SNGs and the per-pixel ones-counters for exactly BSL bitstream cycles.
//  - Then streams the interior pixel counts out over a valid/ready port.
//  Sits between the host/frame buffer and the SNG -> median array -> counter-array datapath.
// PARAMETERS
//  M        32                rows in frame
//  N        32                columns in frame
//  BSL      256               bitstream length (cycles counted per frame)
//  LFSR_W   8                 LFSR width
//  TAPS     8'hB8             Galois feedback mask (maximal length for LFSR_W=8)
//  PIPE_LAT 1                 cycles from sng_en to first valid filter output bit
//  RD_LAT   1                 counter-array read latency (rd_addr -> rd_data), >=1
//  CNT_W    $clog2(BSL+1)     count width
//  AW       $clog2(M*N)       pixel address width
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  start      in   1       begin frame; sampled only in IDLE
//  abort      in   1       synchronous cancel, any state
//  seed_in    in   LFSR_W  LFSR seed, sampled with start
//  busy       out  1       high in every state except IDLE
//  done       out  1       one-cycle pulse after last pixel accepted
//  lfsr_out   out  LFSR_W  shared random word to SNG comparators
//  sng_en     out  1       SNGs produce bits this cycle
//  cnt_clr    out  1       clear all pixel counters (one cycle)
//  cnt_en     out  1       counters accumulate median output bit
//  rd_addr    out  AW      counter-array read address
//  rd_data    in   CNT_W   count at rd_addr, RD_LAT cycles later
//  out_valid  out  1       out_pixel/out_idx valid
//  out_ready  in   1       downstream accepts
//  out_pixel  out  CNT_W   ones count of one filtered pixel
//  out_idx    out  AW      linear pixel index r*N+c
//  out_last   out  1       qualifies final interior pixel
// BEHAVIOUR
//  Reset (reset==0), all outputs 0:
//  - State IDLE; lfsr=1, counters 0.
//  FSM states: IDLE -> LOAD -> CLEAR -> STREAM -> RADDR -> RWAIT -> OUT -> (RADDR | DONE) -> IDLE.
//  IDLE:
//  - start=1 -> LOAD.
//  LOAD (1 cycle):
//  - lfsr <= seed_in (captured at start); seed 0 is replaced by 1 (lockup avoidance).
//  CLEAR (1 cycle):
//  - cnt_clr=1.
//  STREAM lasts BSL+PIPE_LAT cycles; cycle counter cyc runs 0..BSL+PIPE_LAT-1.
//  - sng_en=1 for cyc<BSL; LFSR steps each such cycle: lfsr <= (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
//  - cnt_en=1 for PIPE_LAT<=cyc<BSL+PIPE_LAT, i.e. exactly BSL cycles.
//  - lfsr_out = lfsr register, held when sng_en=0.
//  Readout:
//  - Only interior pixels r=1..M-2, c=1..N-2, row-major (border outputs are undriven by the filter).
//  - RADDR: rd_addr = r*N+c, then RWAIT RD_LAT-1 cycles.
//  - OUT: out_pixel <= rd_data, out_idx <= rd_addr, out_valid=1.
//  - out_valid/out_pixel/out_idx/out_last held stable until out_ready=1.
//  - Transfer on out_valid&&out_ready: c wraps N-2 -> 1 with r+1.
//  - After the transfer with r=M-2, c=N-2 (out_last=1) -> DONE.
//  DONE:
//  - done=1 for one cycle -> IDLE; busy=0 the cycle after DONE.
//  Edge cases:
//  - out_ready high before out_valid has no effect.
//  - start while busy is ignored.
//  - start and abort together in IDLE: abort wins, stay IDLE.
//  - abort=1 in any state -> IDLE next cycle: all outputs 0, no done pulse, lfsr not reset (next LOAD reseeds).
//  - Async reset mid-frame: immediate IDLE with reset values; counter contents undefined, next frame's CLEAR fixes them.
//  - Interior pixel count per frame = (M-2)*(N-2); requires M,N>=3.
// TESTING
//  1. Reset checks:
//     - Reset mid-STREAM -> all outputs 0 immediately, busy=0.
//     - start after release -> full normal frame.
//  2. M=N=4, BSL=16, seed 8'hA5, out_ready=1, PIPE_LAT=1:
//     - Exactly one cnt_clr pulse; sng_en high exactly 16 cycles; cnt_en high 16 cycles, offset by 1 cycle.
//     - Readout idx 5,6,9,10; out_last only on 10; done 1 cycle.
//  3. Seed 0 -> lfsr_out first value after LOAD = 8'h01, next = 8'hB8.
//     - 255 steps return to start value, no repeat sooner.
//  4. Backpressure: out_ready random 30% -> data/idx stable while valid&&!ready.
//     - No skipped or duplicated idx; 900 transfers for 32x32 defaults.
//  5. Abort in STREAM cycle 5 and again in OUT -> IDLE next cycle, no done.
//     - start with same seed reproduces identical lfsr_out sequence and counts.
//  6. RD_LAT=3 with model memory rd_data=addr:
//     - Every out_pixel==out_idx (truncated to CNT_W).
//     - start pulsed while busy -> ignored.

Source files
------------

// File: rtl/sc_noise_frame_ctrl.sv
// sc_noise_frame_ctrl: sequences one stochastic-computing frame (seed, clear, BSL-cycle stream, interior readout).
module sc_noise_frame_ctrl #(
  parameter int M = 32,
  parameter int N = 32,
  parameter int BSL = 256,
  parameter int LFSR_W = 8,
  parameter logic [LFSR_W-1:0] TAPS = 8'hB8,
  parameter int PIPE_LAT = 1,
  parameter int RD_LAT = 1,
  parameter int CNT_W = $clog2(BSL+1),
  parameter int AW = $clog2(M*N)
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              busy,
  output logic              done,
  output logic [LFSR_W-1:0] lfsr_out,
  output logic              sng_en,
  output logic              cnt_clr,
  output logic              cnt_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [CNT_W-1:0]  rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_pixel,
  output logic [AW-1:0]     out_idx,
  output logic              out_last
);
  localparam int CW = $clog2(BSL+PIPE_LAT+1);
  localparam int WW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] SNG_END = CW'(BSL);
  localparam logic [CW-1:0] CNT_BEG = CW'(PIPE_LAT);
  localparam logic [CW-1:0] CNT_END = CW'(BSL+PIPE_LAT);
  localparam logic [CW-1:0] CYC_LAST = CW'(BSL+PIPE_LAT-1);
  localparam logic [WW-1:0] W_LAST = WW'(RD_LAT > 1 ? RD_LAT-2 : 0);
  localparam logic [AW-1:0] FIRST = AW'(N+1);
  localparam logic [AW-1:0] LAST = AW'((M-2)*N+N-2);
  localparam logic [AW-1:0] COL_LAST = AW'(N-2);
  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, STREAM, RADDR, RWAIT, OUT, DONE} state_t;
  state_t state;
  logic [LFSR_W-1:0] lfsr, seed_q;
  logic [CW-1:0] cyc;
  logic [WW-1:0] w;
  logic [AW-1:0] c;
  function automatic logic [LFSR_W-1:0] step(input logic [LFSR_W-1:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : '0);
  endfunction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      lfsr <= LFSR_W'(1);
      seed_q <= '0;
      cyc <= '0;
      w <= '0;
      c <= '0;
      {busy, done, sng_en, cnt_clr, cnt_en, out_valid, out_last} <= '0;
      lfsr_out <= '0;
      rd_addr <= '0;
      out_pixel <= '0;
      out_idx <= '0;
    end else if (abort || state == DONE) begin
      // abort and normal completion share the return to IDLE; lfsr keeps its value, LOAD reseeds
      state <= IDLE;
      {busy, done, sng_en, cnt_clr, cnt_en, out_valid, out_last} <= '0;
      lfsr_out <= '0;
      rd_addr <= '0;
      out_pixel <= '0;
      out_idx <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          seed_q <= seed_in;
          busy <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          lfsr <= (seed_q == '0) ? LFSR_W'(1) : seed_q;
          lfsr_out <= (seed_q == '0) ? LFSR_W'(1) : seed_q;
          cnt_clr <= 1'b1;
          state <= CLEAR;
        end
        CLEAR: begin
          cnt_clr <= 1'b0;
          cyc <= '0;
          sng_en <= 1'b1;
          cnt_en <= (PIPE_LAT == 0);
          state <= STREAM;
        end
        STREAM: begin
          if (sng_en) begin
            lfsr <= step(lfsr);
            lfsr_out <= step(lfsr);
          end
          cyc <= cyc + CW'(1);
          sng_en <= (cyc + CW'(1)) < SNG_END;
          cnt_en <= (cyc + CW'(1)) >= CNT_BEG && (cyc + CW'(1)) < CNT_END;
          if (cyc == CYC_LAST) begin
            sng_en <= 1'b0;
            cnt_en <= 1'b0;
            rd_addr <= FIRST;
            c <= AW'(1);
            state <= RADDR;
          end
        end
        RADDR: begin
          w <= '0;
          state <= (RD_LAT == 1) ? OUT : RWAIT;
        end
        RWAIT: begin
          w <= w + WW'(1);
          if (w == W_LAST) state <= OUT;
        end
        OUT: begin
          // first OUT cycle captures rd_data; the word is then held until accepted
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_pixel <= rd_data;
            out_idx <= rd_addr;
            out_last <= rd_addr == LAST;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
            if (out_last) begin
              done <= 1'b1;
              state <= DONE;
            end else begin
              c <= (c == COL_LAST) ? AW'(1) : c + AW'(1);
              rd_addr <= rd_addr + ((c == COL_LAST) ? AW'(3) : AW'(1));
              state <= RADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sc_noise_frame_ctrl.sv
// tb_sc_noise_frame_ctrl: directed bench on a 4x4, BSL=16, RD_LAT=3 instance with an rd_data=addr memory.
module tb_sc_noise_frame_ctrl;
  localparam int M = 4, N = 4, BSL = 16, LW = 8, PL = 1, RL = 3;
  localparam int CW = $clog2(BSL+1), AW = $clog2(M*N);
  logic clk = 0, rst_n = 0, start = 0, abort = 0, out_ready = 1;
  logic rdy_rand = 0, rdy_fix = 1;
  logic [LW-1:0] seed_in = '0;
  logic busy, done, sng_en, cnt_clr, cnt_en, out_valid, out_last;
  logic [LW-1:0] lfsr_out;
  logic [AW-1:0] rd_addr, out_idx;
  logic [CW-1:0] rd_data, out_pixel;
  logic [AW-1:0] pipe [RL];
  int checks = 0, failures = 0;
  int n_clr, n_sng, n_cnt, f_sng, f_cnt, n_last, n_done, cyc;
  int idxq[$];
  int exp_idx[4] = '{5, 6, 9, 10};
  logic [AW-1:0] last_idx;
  logic [LW-1:0] seq [16];
  logic [LW-1:0] ref_seq [16];
  logic pv = 0, pr = 0, pa = 0;
  logic [AW-1:0] pidx;
  logic [CW-1:0] ppix;
  logic [LW-1:0] v;
  sc_noise_frame_ctrl #(.M(M), .N(N), .BSL(BSL), .LFSR_W(LW), .TAPS(8'hB8), .PIPE_LAT(PL), .RD_LAT(RL)) dut (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort), .seed_in(seed_in),
    .busy(busy), .done(done), .lfsr_out(lfsr_out), .sng_en(sng_en), .cnt_clr(cnt_clr),
    .cnt_en(cnt_en), .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_pixel(out_pixel), .out_idx(out_idx), .out_last(out_last)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    pipe[0] <= rd_addr;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign rd_data = CW'(pipe[RL-1]);
  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? ($urandom_range(0, 99) < 30) : rdy_fix;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (start && !busy && !abort && rst_n) begin
      n_clr = 0; n_sng = 0; n_cnt = 0; f_sng = -1; f_cnt = -1; n_last = 0; n_done = 0;
      idxq.delete();
    end
    if (cnt_clr) n_clr++;
    if (sng_en) begin
      if (n_sng < 16) seq[n_sng] = lfsr_out;
      if (f_sng < 0) f_sng = cyc;
      n_sng++;
    end
    if (cnt_en) begin
      if (f_cnt < 0) f_cnt = cyc;
      n_cnt++;
    end
    if (pv && !pr && !pa && rst_n) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_idx", out_idx, pidx);
      chk("hold_pix", out_pixel, ppix);
    end
    if (out_valid && out_ready) begin
      idxq.push_back(int'(out_idx));
      chk("pix_eq_idx", out_pixel, CW'(out_idx));
      if (out_last) begin
        n_last++;
        last_idx = out_idx;
      end
    end
    if (done) n_done++;
    pv = out_valid; pr = out_ready; pa = abort; pidx = out_idx; ppix = out_pixel;
    cyc++;
  end
  task automatic stp();
    @(posedge clk);
    #2;
  endtask
  task automatic kick(input logic [LW-1:0] s);
    stp();
    seed_in = s;
    start = 1;
    stp();
    start = 0;
  endtask
  task automatic wait_done();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", done, 1);
    chk("busy_in_done", busy, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask
  task automatic wait_sng(input int n);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (n_sng >= n) break;
    end
    chk("reach_stream", n_sng >= n, 1);
  endtask
  task automatic check_frame();
    chk("clr_pulses", n_clr, 1);
    chk("sng_cycles", n_sng, BSL);
    chk("cnt_cycles", n_cnt, BSL);
    chk("cnt_offset", f_cnt - f_sng, PL);
    chk("xfers", idxq.size(), 4);
    for (int i = 0; i < 4; i++) if (i < idxq.size()) chk("idx_order", idxq[i], exp_idx[i]);
    chk("last_count", n_last, 1);
    chk("last_idx", last_idx, 10);
    chk("done_cycles", n_done, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_lfsr_out", lfsr_out, 0);
    chk("rst_sng_en", sng_en, 0);
    chk("rst_cnt_clr", cnt_clr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_done", done, 0);
    stp();
    rst_n = 1;
    kick(8'hA5);
    wait_done();
    check_frame();
    chk("a5_s0", seq[0], 8'hA5);
    chk("a5_s1", seq[1], 8'hEA);
    chk("a5_s2", seq[2], 8'h75);
    chk("a5_s3", seq[3], 8'h82);
    v = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      chk("a5_seq", seq[i], v);
      v = (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
      ref_seq[i] = seq[i];
    end
    kick(8'h00);
    wait_done();
    check_frame();
    chk("seed0_s0", seq[0], 8'h01);
    chk("seed0_s1", seq[1], 8'hB8);
    chk("seed0_s2", seq[2], 8'h5C);
    rdy_rand = 1;
    kick(8'h3C);
    wait_done();
    check_frame();
    rdy_rand = 0;
    kick(8'hA5);
    wait_sng(5);
    stp();
    abort = 1;
    stp();
    abort = 0;
    @(negedge clk);
    chk("abort_s_busy", busy, 0);
    chk("abort_s_sng", sng_en, 0);
    chk("abort_s_cnt", cnt_en, 0);
    chk("abort_s_lfsr", lfsr_out, 0);
    repeat (5) @(negedge clk);
    chk("abort_s_nodone", n_done, 0);
    kick(8'hA5);
    wait_done();
    check_frame();
    for (int i = 0; i < 16; i++) chk("repro_seq", seq[i], ref_seq[i]);
    rdy_fix = 0;
    kick(8'h11);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("reach_out", out_valid, 1);
    stp();
    abort = 1;
    stp();
    abort = 0;
    @(negedge clk);
    chk("abort_o_valid", out_valid, 0);
    chk("abort_o_idx", out_idx, 0);
    chk("abort_o_busy", busy, 0);
    chk("abort_o_addr", rd_addr, 0);
    repeat (3) @(negedge clk);
    chk("abort_o_nodone", n_done, 0);
    rdy_fix = 1;
    stp();
    start = 1;
    abort = 1;
    stp();
    start = 0;
    abort = 0;
    @(negedge clk);
    chk("start_abort_idle", busy, 0);
    repeat (2) @(negedge clk);
    chk("start_abort_idle2", busy, 0);
    kick(8'hA5);
    wait_sng(3);
    stp();
    seed_in = 8'h77;
    start = 1;
    stp();
    start = 0;
    wait_done();
    check_frame();
    chk("busy_start_seed", seq[0], 8'hA5);
    repeat (3) @(negedge clk);
    chk("no_restart", busy, 0);
    kick(8'h5A);
    wait_sng(3);
    stp();
    rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_sng", sng_en, 0);
    chk("arst_cnt", cnt_en, 0);
    chk("arst_lfsr", lfsr_out, 0);
    chk("arst_clr", cnt_clr, 0);
    stp();
    stp();
    rst_n = 1;
    kick(8'hA5);
    wait_done();
    check_frame();
    for (int i = 0; i < 16; i++) chk("post_rst_seq", seq[i], ref_seq[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
